// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - register file initiator: operand fetch FSM with write bypass and one-entry writeback buffer
module regfile_access_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [XLEN-1:0]   op_a,
    output logic [XLEN-1:0]   op_b,
    output logic [ADDR_W-1:0] op_rd,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [ADDR_W-1:0] rf_a1,
    output logic [ADDR_W-1:0] rf_a2,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [XLEN-1:0]   rf_wd3,
    output logic              rf_we3,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] rf_a1_q, rf_a2_q, rf_a3_q, op_rd_q;
    logic [XLEN-1:0]   rf_wd3_q, op_a_q, op_b_q;
    logic              rf_we3_q, pending_q, op_valid_q;
    logic [XLEN-1:0]   byp1, byp2;
    logic              instr_fire, wb_fire;
    logic              unused_instr_bits;

    assign unused_instr_bits = ^{instr[31:25], instr[14:12], instr[6:0]};

    assign instr_ready = (state_q == IDLE);
    assign instr_fire  = instr_ready && instr_valid;
    assign wb_ready    = !pending_q;
    assign wb_fire     = wb_valid && wb_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid) state_d = FETCH;
            FETCH:   state_d = HOLD;
            HOLD:    if (op_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A write pulsing this cycle has not reached the file yet, so forward it; x0 reads as zero.
    always_comb begin
        byp1 = rf_rd1;
        byp2 = rf_rd2;
        if (rf_a1_q == '0) begin
            byp1 = '0;
        end else if (rf_we3_q && (rf_a3_q == rf_a1_q)) begin
            byp1 = rf_wd3_q;
        end
        if (rf_a2_q == '0) begin
            byp2 = '0;
        end else if (rf_we3_q && (rf_a3_q == rf_a2_q)) begin
            byp2 = rf_wd3_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_a1_q    <= '0;
            rf_a2_q    <= '0;
            op_rd_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
        end else begin
            if (instr_fire) begin
                rf_a1_q <= instr[19:15];
                rf_a2_q <= instr[24:20];
                op_rd_q <= instr[11:7];
            end
            if (state_q == FETCH) begin
                op_a_q     <= byp1;
                op_b_q     <= byp2;
                op_valid_q <= 1'b1;
            end else if ((state_q == HOLD) && op_ready) begin
                op_valid_q <= 1'b0;
            end
        end
    end

    // The pending flag blocks acceptance for the pulse cycle, giving one write per two cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_a3_q   <= '0;
            rf_wd3_q  <= '0;
            rf_we3_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            if (wb_fire) begin
                rf_a3_q   <= wb_rd;
                rf_wd3_q  <= wb_data;
                rf_we3_q  <= (wb_rd != '0);
                pending_q <= 1'b1;
            end else begin
                rf_we3_q  <= 1'b0;
                pending_q <= 1'b0;
            end
        end
    end

    assign op_valid = op_valid_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_rd    = op_rd_q;
    assign rf_a1    = rf_a1_q;
    assign rf_a2    = rf_a2_q;
    assign rf_a3    = rf_a3_q;
    assign rf_wd3   = rf_wd3_q;
    assign rf_we3   = rf_we3_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb/tb_regfile_access_ctrl.sv - table-driven bench for regfile_access_ctrl with a behavioural register file
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, instr_ready;
    logic [31:0] instr;
    logic        op_valid, op_ready;
    logic [31:0] op_a, op_b;
    logic [4:0]  op_rd;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rf_a1, rf_a2, rf_a3;
    logic [31:0] rf_wd3, rf_rd1, rf_rd2;
    logic        rf_we3;
    logic        force_ff;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [32] = '{default: 32'h0};

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_we3) mem[rf_a3] <= rf_wd3;
    assign rf_rd1 = force_ff ? 32'hFFFF_FFFF : mem[rf_a1];
    assign rf_rd2 = force_ff ? 32'hFFFF_FFFF : mem[rf_a2];

    regfile_access_ctrl #(.XLEN(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [4:0]  erd;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        int n;
        n = 0;
        while (!wb_ready && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        check("wb_ready_wait", {31'b0, wb_ready}, 32'd1);
        wb_valid = 1'b1; wb_rd = rd; wb_data = data;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input string name, input logic [31:0] iw, input logic [31:0] ea,
                             input logic [31:0] eb, input logic [4:0] erd);
        int n;
        check({name, "_instr_ready"}, {31'b0, instr_ready}, 32'd1);
        instr_valid = 1'b1; instr = iw;
        n = 0;
        do begin
            @(posedge clk); #1;
            instr_valid = 1'b0;
            n++;
        end while (!op_valid && n < 10);
        check({name, "_latency"}, n, 32'd2);
        @(negedge clk);
        check({name, "_op_a"}, op_a, ea);
        check({name, "_op_b"}, op_b, eb);
        check({name, "_op_rd"}, {27'b0, op_rd}, {27'b0, erd});
        op_ready = 1'b1;
        @(posedge clk); #1;
        op_ready = 1'b0;
        check({name, "_drop_valid"}, {31'b0, op_valid}, 32'd0);
        check({name, "_back_idle"}, {31'b0, instr_ready}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{32'h002081B3, 32'h5,         32'h7,         32'h5,         32'h7,         5'd3};
        vecs[1] = '{32'h00628533, 32'hA5A5A5A5,  32'h0000FFFF,  32'hA5A5A5A5,  32'h0000FFFF,  5'd10};
        vecs[2] = '{32'h01FF8FB3, 32'h80000001,  32'h80000001,  32'h80000001,  32'h80000001,  5'd31};
        vecs[3] = '{32'h007000B3, 32'hCAFEF00D,  32'h12345678,  32'h0,         32'h12345678,  5'd1};
        vecs[4] = '{32'h002081B3, 32'h5,         32'h7,         32'h5,         32'h7,         5'd3};

        rst = 1'b1; instr_valid = 1'b0; instr = 32'h0; op_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; force_ff = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_op_valid", {31'b0, op_valid}, 32'd0);
        check("rst_we3", {31'b0, rf_we3}, 32'd0);
        check("rst_wb_ready", {31'b0, wb_ready}, 32'd1);
        check("rst_op_a", op_a, 32'd0);
        check("rst_a1", {27'b0, rf_a1}, 32'd0);
        check("rst_a3", {27'b0, rf_a3}, 32'd0);
        check("rst_wd3", rf_wd3, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].instr[19:15] != 5'd0) wb_write(vecs[i].instr[19:15], vecs[i].v1);
            if (vecs[i].instr[24:20] != 5'd0) wb_write(vecs[i].instr[24:20], vecs[i].v2);
            run_instr($sformatf("vec%0d", i), vecs[i].instr, vecs[i].ea, vecs[i].eb, vecs[i].erd);
        end

        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'hDEADBEEF;
        @(negedge clk);
        check("wb4_accept_ready", {31'b0, wb_ready}, 32'd1);
        check("wb4_no_early_we", {31'b0, rf_we3}, 32'd0);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        @(negedge clk);
        check("wb4_we", {31'b0, rf_we3}, 32'd1);
        check("wb4_a3", {27'b0, rf_a3}, 32'd4);
        check("wb4_wd3", rf_wd3, 32'hDEADBEEF);
        check("wb4_busy", {31'b0, wb_ready}, 32'd0);
        @(negedge clk);
        check("wb4_we_clear", {31'b0, rf_we3}, 32'd0);
        check("wb4_ready_again", {31'b0, wb_ready}, 32'd1);
        check("wb4_a3_hold", {27'b0, rf_a3}, 32'd4);
        check("wb4_mem", mem[4], 32'hDEADBEEF);
        @(posedge clk); #1;

        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        @(negedge clk);
        check("wb0_handshake", {31'b0, wb_ready}, 32'd0);
        check("wb0_no_we", {31'b0, rf_we3}, 32'd0);
        check("wb0_wd3", rf_wd3, 32'h1234);
        @(negedge clk);
        check("wb0_no_we_after", {31'b0, rf_we3}, 32'd0);
        @(posedge clk); #1;

        wb_write(5'd1, 32'h11);
        instr_valid = 1'b1; instr = 32'h002081B3;
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
        @(posedge clk); #1;
        instr_valid = 1'b0; wb_valid = 1'b0;
        @(negedge clk);
        check("byp_file_old", rf_rd1, 32'h11);
        check("byp_we_in_fetch", {31'b0, rf_we3}, 32'd1);
        @(negedge clk);
        check("byp_op_valid", {31'b0, op_valid}, 32'd1);
        check("byp_op_a", op_a, 32'h55);
        check("byp_op_b", op_b, 32'h7);
        op_ready = 1'b1;
        @(posedge clk); #1;
        op_ready = 1'b0;
        run_instr("after_byp", 32'h002081B3, 32'h55, 32'h7, 5'd3);

        force_ff = 1'b1;
        run_instr("x0_forced", 32'h00000033, 32'h0, 32'h0, 5'd0);
        force_ff = 1'b0;

        instr_valid = 1'b1; instr = 32'h00628533;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check("hold_valid_up", {31'b0, op_valid}, 32'd1);
        wb_write(5'd5, 32'h0BADF00D);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d_valid", k), {31'b0, op_valid}, 32'd1);
            check($sformatf("hold%0d_op_a", k), op_a, 32'hA5A5A5A5);
            check($sformatf("hold%0d_op_b", k), op_b, 32'h0000FFFF);
            check($sformatf("hold%0d_ready", k), {31'b0, instr_ready}, 32'd0);
        end
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99999999;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        check("pre_rst_we", {31'b0, rf_we3}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_hold_valid", {31'b0, op_valid}, 32'd0);
        check("rst_hold_we", {31'b0, rf_we3}, 32'd0);
        check("rst_hold_op_a", op_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", {31'b0, instr_ready}, 32'd1);
        check("post_rst_valid", {31'b0, op_valid}, 32'd0);
        check("post_rst_no_write", mem[9], 32'd0);
        run_instr("post_rst", 32'h00628533, 32'h0BADF00D, 32'h0000FFFF, 5'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
